// File: rtl/nal_byte_parser_pkg.sv
// rtl/nal_byte_parser_pkg.sv - shared constants, parser state encoding and zero-counter helper
// Contents: START_CODE_BYTE, EPB_BYTE, NAL_TYPE_W, parse_state_t, zcnt_inc()
package nal_byte_parser_pkg;

  localparam logic [7:0] START_CODE_BYTE = 8'h01;
  localparam logic [7:0] EPB_BYTE        = 8'h03;
  localparam int         NAL_TYPE_W      = 5;

  typedef enum logic [1:0] {
    HUNT,
    BODY,
    FLUSHZ
  } parse_state_t;

  // Held-zero counter saturates at 3: "three or more" is all the parser distinguishes.
  function automatic logic [1:0] zcnt_inc(input logic [1:0] z);
    return (z == 2'd3) ? z : z + 2'd1;
  endfunction

endpackage

// File: rtl/nal_byte_parser_if.sv
// rtl/nal_byte_parser_if.sv - NAL payload byte stream (valid/ready with first/last tags)
// Signals: nal_data[7:0], nal_valid, nal_ready, nal_first, nal_last
// Modports: master drives data/valid/first/last; slave drives ready.
interface nal_byte_parser_if;

  logic [7:0] nal_data;
  logic       nal_valid;
  logic       nal_ready;
  logic       nal_first;
  logic       nal_last;

  modport master (
    output nal_data, nal_valid, nal_first, nal_last,
    input  nal_ready
  );

  modport slave (
    input  nal_data, nal_valid, nal_first, nal_last,
    output nal_ready
  );

endinterface

// File: rtl/nal_byte_parser_out_reg.sv
// rtl/nal_byte_parser_out_reg.sv - 1-deep valid/ready output register with first/last sideband
// Ports: clk, reset (async high); load + load_data/first/last in; ready in;
//        valid/data/first/last out; free = register may be loaded this cycle.
module nal_byte_parser_out_reg (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [7:0] load_data,
  input  logic       load_first,
  input  logic       load_last,
  input  logic       ready,
  output logic       valid,
  output logic [7:0] data,
  output logic       first,
  output logic       last,
  output logic       free
);

  // The producer only loads when free, so contents never change while stalled.
  assign free = !valid || ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid <= 1'b0;
      data  <= 8'h00;
      first <= 1'b0;
      last  <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      data  <= load_data;
      first <= load_first;
      last  <= load_last;
    end else if (ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/nal_byte_parser.sv
// rtl/nal_byte_parser.sv - H.264 Annex-B start-code parser with emulation-prevention stripping
// Ports: clk, reset (async high); fifo_valid/fifo_data in, fifo_read out (FWFT pop);
//        stream_over in (flush final NAL); nal (master stream); nal_type, nal_error (sticky),
//        nal_count (completed NALs, wraps).
module nal_byte_parser
  import nal_byte_parser_pkg::*;
#(
  parameter int CNT_W     = 16,
  parameter bit STRIP_EPB = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  fifo_valid,
  input  logic [7:0]            fifo_data,
  output logic                  fifo_read,
  input  logic                  stream_over,
  nal_byte_parser_if.master     nal,
  output logic [NAL_TYPE_W-1:0] nal_type,
  output logic                  nal_error,
  output logic [CNT_W-1:0]      nal_count
);

  parse_state_t state, state_n;
  logic [1:0]   zcnt, zcnt_n;
  logic [7:0]   hold_byte, hold_byte_n;
  logic         hold_valid, hold_valid_n;
  logic [7:0]   pend_byte;
  logic         pend_first, pend_valid, first_pend;
  logic         rd, push, close, err_set, start_nal;
  logic [7:0]   push_byte;
  logic         out_free;

  // PEND always trails by one byte so the NAL's final byte can be tagged last
  // once the closing start code (or end of stream) is seen.
  nal_byte_parser_out_reg u_out (
    .clk        (clk),
    .reset      (reset),
    .load       (pend_valid && (push || close)),
    .load_data  (pend_byte),
    .load_first (pend_first),
    .load_last  (close),
    .ready      (nal.nal_ready),
    .valid      (nal.nal_valid),
    .data       (nal.nal_data),
    .first      (nal.nal_first),
    .last       (nal.nal_last),
    .free       (out_free)
  );

  always_comb begin
    state_n      = state;
    zcnt_n       = zcnt;
    hold_byte_n  = hold_byte;
    hold_valid_n = hold_valid;
    rd           = 1'b0;
    push         = 1'b0;
    close        = 1'b0;
    err_set      = 1'b0;
    start_nal    = 1'b0;
    push_byte    = fifo_data;
    case (state)
      HUNT: begin
        if (fifo_valid) begin
          rd = 1'b1;
          if (fifo_data == 8'h00) begin
            zcnt_n = zcnt_inc(zcnt);
          end else begin
            zcnt_n = 2'd0;
            if (fifo_data == START_CODE_BYTE && zcnt[1]) begin
              state_n   = BODY;
              start_nal = 1'b1;
            end
          end
        end
      end
      BODY: begin
        if (fifo_valid) begin
          if (fifo_data == 8'h00) begin
            rd     = 1'b1;
            zcnt_n = zcnt_inc(zcnt);
          end else if (fifo_data == START_CODE_BYTE && zcnt[1]) begin
            // Held zeros belong to the start code; an empty PEND needs no OUT slot.
            if (!pend_valid || out_free) begin
              rd     = 1'b1;
              close  = 1'b1;
              zcnt_n = 2'd0;
            end
          end else if (zcnt == 2'd0 || zcnt == 2'd3) begin
            // With 3+ zeros the zeros are illegal: drop them and flag the error.
            if (out_free) begin
              rd      = 1'b1;
              push    = 1'b1;
              zcnt_n  = 2'd0;
              err_set = (zcnt == 2'd3);
            end
          end else begin
            // 1..2 real zeros precede this byte; FLUSHZ emits them (zcnt counts down),
            // then the held byte unless it is a stripped emulation-prevention byte.
            rd           = 1'b1;
            state_n      = FLUSHZ;
            hold_byte_n  = fifo_data;
            hold_valid_n = !(STRIP_EPB && fifo_data == EPB_BYTE && zcnt == 2'd2);
          end
        end else if (stream_over) begin
          if (!pend_valid || out_free) begin
            close   = 1'b1;
            zcnt_n  = 2'd0;
            state_n = HUNT;
          end
        end
      end
      FLUSHZ: begin
        if (out_free) begin
          push = 1'b1;
          if (zcnt != 2'd0) begin
            push_byte = 8'h00;
            zcnt_n    = zcnt - 2'd1;
            if (zcnt == 2'd1 && !hold_valid) state_n = BODY;
          end else begin
            push_byte    = hold_byte;
            hold_valid_n = 1'b0;
            state_n      = BODY;
          end
        end
      end
      default: state_n = HUNT;
    endcase
  end

  assign fifo_read = rd && !reset;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= HUNT;
      zcnt       <= 2'd0;
      hold_byte  <= 8'h00;
      hold_valid <= 1'b0;
      pend_byte  <= 8'h00;
      pend_first <= 1'b0;
      pend_valid <= 1'b0;
      first_pend <= 1'b0;
      nal_type   <= '0;
      nal_error  <= 1'b0;
      nal_count  <= '0;
    end else begin
      state      <= state_n;
      zcnt       <= zcnt_n;
      hold_byte  <= hold_byte_n;
      hold_valid <= hold_valid_n;
      if (start_nal || close) first_pend <= 1'b1;
      else if (push)          first_pend <= 1'b0;
      if (push) begin
        pend_byte  <= push_byte;
        pend_first <= first_pend;
        pend_valid <= 1'b1;
        if (first_pend) nal_type <= push_byte[NAL_TYPE_W-1:0];
      end else if (close) begin
        pend_valid <= 1'b0;
      end
      if (err_set) nal_error <= 1'b1;
      if (nal.nal_valid && nal.nal_ready && nal.nal_last) nal_count <= nal_count + CNT_W'(1);
    end
  end

endmodule
